// File: rtl/dmem_dual_sequencer.sv
// Shares one SRAM-like data port between two issue slots; a dual access runs slot 1 then slot 2.
// Optional build macro DMEM_PERF_CNT_EN adds stall-cycle and dual-access performance counters.
module dmem_dual_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic        exp1,
    input  logic        exp2,
    input  logic        mem_en1,
    input  logic        mem_en2,
    input  logic        mem_wen1,
    input  logic        mem_wen2,
    input  logic [1:0]  mem_size1,
    input  logic [1:0]  mem_size2,
    input  logic [31:0] mem_addr1,
    input  logic [31:0] mem_addr2,
    input  logic [31:0] mem_wdata1,
    input  logic [31:0] mem_wdata2,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_dual_cnt
`endif
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ1  = 3'd1,
        S_WAIT1 = 3'd2,
        S_REQ2  = 3'd3,
        S_WAIT2 = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic          wen;
        logic [SW-1:0] size;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } slot_t;

    state_t state, state_nxt;
    slot_t  slot1_q, slot2_q;
    logic   sel2_q;
    logic   abort_q, abort_nxt;
    logic   sel1_c, sel2_c, go_c;
    logic   cap1_c, cap2_c;

    // Exception in slot 1 kills slot 2 as well (younger instruction).
    assign sel1_c = mem_en1 & ~exp1;
    assign sel2_c = mem_en2 & ~exp1 & ~exp2;
    assign go_c   = (state == S_IDLE) & start & ~flush & (sel1_c | sel2_c);
    assign stall  = go_c | ((state != S_IDLE) & (state != S_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            abort_q <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        abort_nxt  = abort_q;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = '0;
        data_addr  = '0;
        data_wdata = '0;
        done       = 1'b0;
        cap1_c     = 1'b0;
        cap2_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (go_c) state_nxt = sel1_c ? S_REQ1 : S_REQ2;
            end
            S_REQ1: begin
                data_req   = 1'b1;
                data_wr    = slot1_q.wen;
                data_size  = slot1_q.size;
                data_addr  = slot1_q.addr;
                data_wdata = slot1_q.wdata;
                if (flush)             state_nxt = S_IDLE;
                else if (data_addr_ok) state_nxt = S_WAIT1;
            end
            S_WAIT1: begin
                // An aborted access still drains its response before releasing the bus.
                if (data_data_ok) begin
                    abort_nxt = 1'b0;
                    if (abort_q | flush) begin
                        state_nxt = S_IDLE;
                    end else begin
                        cap1_c    = ~slot1_q.wen;
                        state_nxt = sel2_q ? S_REQ2 : S_DONE;
                    end
                end else if (flush) begin
                    abort_nxt = 1'b1;
                end
            end
            S_REQ2: begin
                data_req   = 1'b1;
                data_wr    = slot2_q.wen;
                data_size  = slot2_q.size;
                data_addr  = slot2_q.addr;
                data_wdata = slot2_q.wdata;
                if (flush)             state_nxt = S_IDLE;
                else if (data_addr_ok) state_nxt = S_WAIT2;
            end
            S_WAIT2: begin
                if (data_data_ok) begin
                    abort_nxt = 1'b0;
                    if (abort_q | flush) begin
                        state_nxt = S_IDLE;
                    end else begin
                        cap2_c    = ~slot2_q.wen;
                        state_nxt = S_DONE;
                    end
                end else if (flush) begin
                    abort_nxt = 1'b1;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch and per-slot load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot1_q <= '0;
            slot2_q <= '0;
            sel2_q  <= 1'b0;
            rdata1  <= '0;
            rdata2  <= '0;
        end else begin
            if (go_c) begin
                slot1_q <= '{wen: mem_wen1, size: mem_size1, addr: mem_addr1, wdata: mem_wdata1};
                slot2_q <= '{wen: mem_wen2, size: mem_size2, addr: mem_addr2, wdata: mem_wdata2};
                sel2_q  <= sel2_c;
                rdata1  <= '0;
                rdata2  <= '0;
            end
            if (cap1_c) rdata1 <= data_rdata;
            if (cap2_c) rdata2 <= data_rdata;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_dual_cnt  <= '0;
        end else begin
            if (stall)                     perf_stall_cnt <= perf_stall_cnt + 32'(1);
            if (go_c & sel1_c & sel2_c)    perf_dual_cnt  <= perf_dual_cnt + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_dual_sequencer.sv
// Scoreboard bench for dmem_dual_sequencer: random and directed pairs against a transaction-level model.
module tb_dmem_dual_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, exp1, exp2, mem_en1, mem_en2, mem_wen1, mem_wen2;
    logic [1:0]  mem_size1, mem_size2;
    logic [31:0] mem_addr1, mem_addr2, mem_wdata1, mem_wdata2;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        stall, done;
    logic [31:0] rdata1, rdata2;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_dual_cnt;
`endif

    dmem_dual_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .exp1(exp1), .exp2(exp2),
        .mem_en1(mem_en1), .mem_en2(mem_en2), .mem_wen1(mem_wen1), .mem_wen2(mem_wen2),
        .mem_size1(mem_size1), .mem_size2(mem_size2), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .stall(stall), .done(done), .rdata1(rdata1), .rdata2(rdata2)
`ifdef DMEM_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_dual_cnt(perf_dual_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; bit [1:0] size; bit [31:0] addr; bit [31:0] wdata; } req_t;
    typedef struct { int a; int d; bit [31:0] rdata; } plan_t;
    typedef struct { bit [31:0] r1; bit [31:0] r2; } res_t;
    typedef struct {
        bit en1, en2, wen1, wen2, e1, e2;
        bit [1:0] sz1, sz2;
        bit [31:0] a1, a2, w1, w2;
    } pair_t;

    req_t  req_q[$];
    plan_t plan_q[$];
    res_t  res_q[$];
    int    run_q[$];
    int    tests = 0;
    int    fails = 0;
    longint exp_stall_sum = 0;
    longint exp_dual = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic missing(string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT event with no expected entry", name);
    endtask

    // Monitor: bus handshakes, done pulses and stall-run lengths.
    int run_len = 0;
    always @(negedge clk) begin
        req_t r;
        res_t e;
        if (data_req && data_addr_ok) begin
            if (req_q.size() == 0) missing("bus_req");
            else begin
                r = req_q.pop_front();
                check("req_wr", 64'(data_wr), 64'(r.wr));
                check("req_size", 64'(data_size), 64'(r.size));
                check("req_addr", 64'(data_addr), 64'(r.addr));
                check("req_wdata", 64'(data_wdata), 64'(r.wdata));
            end
        end
        if (!data_req)
            check("idle_bus_zero", 64'(data_wr | (data_size != 0) | (data_addr != 0) | (data_wdata != 0)), 64'(0));
        if (done) begin
            if (res_q.size() == 0) missing("done");
            else begin
                e = res_q.pop_front();
                check("rdata1", 64'(rdata1), 64'(e.r1));
                check("rdata2", 64'(rdata2), 64'(e.r2));
            end
        end
        if (stall) run_len++;
        else if (run_len > 0) begin
            if (run_q.size() == 0) missing("stall_run");
            else check("stall_run_len", 64'(run_len), 64'(run_q.pop_front()));
            run_len = 0;
        end
    end

    // Bus responder: follows per-access plans for addr_ok/data_ok delays and read data.
    initial begin
        plan_t cur;
        int acnt, dcnt;
        bit have, pending, aok_given;
        logic [31:0] pend_r;
        have = 0; pending = 0; aok_given = 0; acnt = 0; dcnt = 0; pend_r = '0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
        forever begin
            @(posedge clk);
            if (aok_given && !rst) begin
                pending = 1; dcnt = cur.d; pend_r = cur.rdata; have = 0;
            end
            #2;
            aok_given = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom;
            if (rst) begin
                pending = 0; have = 0;
            end else begin
                if (pending) begin
                    if (dcnt == 0) begin
                        data_data_ok = 1; data_rdata = pend_r; pending = 0;
                    end else dcnt--;
                end else if (data_req) begin
                    if (!have) begin
                        if (plan_q.size() == 0) begin
                            missing("bus_plan");
                            cur = '{0, 0, 32'h0};
                        end else cur = plan_q.pop_front();
                        acnt = cur.a; have = 1;
                    end
                    if (acnt == 0) begin
                        data_addr_ok = 1; aok_given = 1;
                    end else acnt--;
                end else begin
                    have = 0;
                    if ($urandom_range(0, 3) == 0) data_data_ok = 1;
                end
            end
        end
    end

    function automatic pair_t rand_pair();
        pair_t p;
        p.en1 = $urandom_range(0, 1) != 0;  p.en2 = $urandom_range(0, 1) != 0;
        p.wen1 = $urandom_range(0, 1) != 0; p.wen2 = $urandom_range(0, 1) != 0;
        p.e1 = $urandom_range(0, 7) == 0;   p.e2 = $urandom_range(0, 7) == 0;
        p.sz1 = 2'($urandom_range(0, 2));   p.sz2 = 2'($urandom_range(0, 2));
        p.a1 = $urandom & ~((32'd1 << p.sz1) - 32'd1);
        p.a2 = $urandom & ~((32'd1 << p.sz2) - 32'd1);
        p.w1 = $urandom; p.w2 = $urandom;
        return p;
    endfunction

    function automatic plan_t rand_plan();
        plan_t pl;
        pl.a = $urandom_range(0, 3); pl.d = $urandom_range(0, 3); pl.rdata = $urandom;
        return pl;
    endfunction

    task automatic drive_pair(pair_t p);
        mem_en1 = p.en1; mem_en2 = p.en2; mem_wen1 = p.wen1; mem_wen2 = p.wen2;
        exp1 = p.e1; exp2 = p.e2; mem_size1 = p.sz1; mem_size2 = p.sz2;
        mem_addr1 = p.a1; mem_addr2 = p.a2; mem_wdata1 = p.w1; mem_wdata2 = p.w2;
        flush = 0;
    endtask

    // Reference model: which slots access the bus, in what order, and what the pair returns.
    task automatic model(pair_t p, plan_t pl1, plan_t pl2, output int nacc);
        bit s1, s2;
        int run;
        res_t r;
        s1 = p.en1 && !p.e1;
        s2 = p.en2 && !p.e1 && !p.e2;
        nacc = 0; run = 0; r = '{32'h0, 32'h0};
        if (s1) begin
            req_q.push_back('{p.wen1, p.sz1, p.a1, p.w1});
            plan_q.push_back(pl1);
            run += pl1.a + pl1.d + 2;
            if (!p.wen1) r.r1 = pl1.rdata;
            nacc++;
        end
        if (s2) begin
            req_q.push_back('{p.wen2, p.sz2, p.a2, p.w2});
            plan_q.push_back(pl2);
            run += pl2.a + pl2.d + 2;
            if (!p.wen2) r.r2 = pl2.rdata;
            nacc++;
        end
        if (nacc > 0) begin
            run += 1;
            run_q.push_back(run);
            res_q.push_back(r);
            exp_stall_sum += run;
        end
        if (s1 && s2) exp_dual++;
    endtask

    task automatic wait_stall_low(string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 200) begin
                missing({name, "_timeout"});
                break;
            end
        end
    endtask

    // Issue one pair; the pipeline keeps start high while stalled (operands scrambled to prove latching).
    task automatic run_pair(pair_t p, plan_t pl1, plan_t pl2);
        int nacc, n;
        @(posedge clk); #1;
        drive_pair(p); start = 1;
        model(p, pl1, pl2, nacc);
        if (nacc == 0) begin
            @(negedge clk);
            check("noacc_stall", 64'(stall), 64'(0));
            check("noacc_req", 64'(data_req), 64'(0));
            return;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 200) begin
                missing("pair_timeout");
                break;
            end
            @(posedge clk); #1;
            drive_pair(rand_pair());
        end
        check("done_after_stall", 64'(done), 64'(1));
    endtask

    initial begin
        pair_t p;
        plan_t pl1, pl2;
        rst = 1; start = 0; drive_pair('{default: 0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_req", 64'(data_req), 64'(0));
        check("rst_data_wr", 64'(data_wr), 64'(0));
        check("rst_data_size", 64'(data_size), 64'(0));
        check("rst_data_addr", 64'(data_addr), 64'(0));
        check("rst_data_wdata", 64'(data_wdata), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rdata1", 64'(rdata1), 64'(0));
        check("rst_rdata2", 64'(rdata2), 64'(0));
        @(posedge clk); #1 rst = 0;

        // Reset mid-request: slot-2-only store held off by a slow bus.
        p = '{default: 0}; p.en2 = 1; p.wen2 = 1; p.sz2 = 2; p.a2 = 32'h40; p.w2 = 32'h11223344;
        @(posedge clk); #1 drive_pair(p); start = 1;
        plan_q.push_back('{20, 0, 32'h0}); run_q.push_back(3);
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1;
        @(negedge clk); check("rstmid_req_before", 64'(data_req), 64'(1));
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        check("rstmid_req_after", 64'(data_req), 64'(0));
        check("rstmid_stall_after", 64'(stall), 64'(0));
        @(posedge clk); #1 rst = 0;
        exp_stall_sum = 0; exp_dual = 0;

        // Single load, slot 1, zero-wait bus.
        p = '{default: 0}; p.en1 = 1; p.sz1 = 2; p.a1 = 32'h80000010;
        run_pair(p, '{0, 0, 32'h12345678}, '{0, 0, 32'h0});

        // Dual: slot 1 store then slot 2 load.
        p = '{default: 0}; p.en1 = 1; p.wen1 = 1; p.sz1 = 2; p.a1 = 32'h100; p.w1 = 32'hAABBCCDD;
        p.en2 = 1; p.sz2 = 2; p.a2 = 32'h104;
        run_pair(p, '{0, 0, 32'h0}, '{0, 0, 32'hCAFEF00D});

        // exp1 kills both slots.
        p.e1 = 1;
        run_pair(p, '{0, 0, 32'h0}, '{0, 0, 32'h0});
        // exp2 kills only slot 2.
        p.e1 = 0; p.e2 = 1; p.wen1 = 0;
        run_pair(p, '{1, 2, 32'h5A5A0001}, '{0, 0, 32'h0});

        // Flush during WAIT1 of a dual pair: drain the response, no REQ2, no done.
        p = '{default: 0}; p.en1 = 1; p.en2 = 1; p.sz1 = 2; p.sz2 = 2; p.a1 = 32'h200; p.a2 = 32'h204;
        @(posedge clk); #1 drive_pair(p); start = 1;
        req_q.push_back('{0, 2, 32'h200, 32'h0}); plan_q.push_back('{0, 3, 32'hDEADBEEF});
        run_q.push_back(6); exp_stall_sum += 6; exp_dual++;
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        wait_stall_low("flush_wait");
        check("flushw_rdata1", 64'(rdata1), 64'(0));
        check("flushw_done", 64'(done), 64'(0));

        // Flush in REQ1 while addr_ok is withheld.
        p = '{default: 0}; p.en1 = 1; p.sz1 = 1; p.a1 = 32'h302;
        @(posedge clk); #1 drive_pair(p); start = 1;
        plan_q.push_back('{4, 0, 32'h0}); run_q.push_back(3); exp_stall_sum += 3;
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1 flush = 1;
        @(negedge clk); check("flushr_req_held", 64'(data_req), 64'(1));
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        check("flushr_req_drop", 64'(data_req), 64'(0));
        check("flushr_stall_drop", 64'(stall), 64'(0));

        // Randomised pairs with random bus delays and idle gaps.
        for (int i = 0; i < 150; i++) begin
            pl1 = rand_plan(); pl2 = rand_plan();
            run_pair(rand_pair(), pl1, pl2);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1 start = 0;
            end
        end
        @(posedge clk); #1 start = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("req_q_empty", 64'(req_q.size()), 64'(0));
        check("res_q_empty", 64'(res_q.size()), 64'(0));
        check("run_q_empty", 64'(run_q.size()), 64'(0));
`ifdef DMEM_PERF_CNT_EN
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(32'(exp_stall_sum)));
        check("perf_dual_cnt", 64'(perf_dual_cnt), 64'(32'(exp_dual)));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
